pattern_scan_ctrl: RTL and testbench

- Sequencing controller for a serial non-overlapping pattern detector.
- Accepts a scan command (byte count plus pattern), pulls that many bytes over a ready/valid stream, and serializes them MSB-first into an embedded detector.
- Counts the detector's match pulses and returns the count through a held result handshake.
- Sits between the byte-oriented ingress path and the bit-serial detection engine.

---
 rtl/pattern_scan_pkg.sv | 20 ++
 rtl/pattern_scan_ctrl_if.sv | 32 +++
 rtl/pattern_det_nonover.sv | 58 +++++
 rtl/pattern_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_scan_pkg.sv
// Shared types and defaults for the pattern scan controller and its serial detector.
package pattern_scan_pkg;

    localparam int unsigned PAT_LEN_DEF = 5;
    localparam int unsigned LEN_W_DEF   = 8;
    localparam int unsigned CNT_W_DEF   = 8;

    // Symbol encoding of the serial alphabet.
    localparam logic SYM_B = 1'b0;
    localparam logic SYM_C = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        DRAIN,
        REPORT
    } scan_state_e;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Command, byte-stream and result handshakes of the pattern scan controller.
interface pattern_scan_ctrl_if
    import pattern_scan_pkg::*;
#(
    parameter int unsigned PAT_LEN = PAT_LEN_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
);

    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic [LEN_W-1:0]   cmd_len_i;
    logic [PAT_LEN-1:0] cmd_pattern_i;
    logic               byte_valid_i;
    logic               byte_ready_o;
    logic [7:0]         byte_i;
    logic               res_valid_o;
    logic               res_ready_i;
    logic [CNT_W-1:0]   res_count_o;
    logic               busy_o;

    modport master (
        output cmd_valid_i, cmd_len_i, cmd_pattern_i, byte_valid_i, byte_i, res_ready_i,
        input  cmd_ready_o, byte_ready_o, res_valid_o, res_count_o, busy_o
    );

    modport slave (
        input  cmd_valid_i, cmd_len_i, cmd_pattern_i, byte_valid_i, byte_i, res_ready_i,
        output cmd_ready_o, byte_ready_o, res_valid_o, res_count_o, busy_o
    );

endinterface

// File: rtl/pattern_det_nonover.sv
// Bit-serial non-overlapping pattern detector; the first bit received lands in pattern_i[PAT_LEN-1].
module pattern_det_nonover
    import pattern_scan_pkg::*;
#(
    parameter int unsigned PAT_LEN = PAT_LEN_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               bit_valid_i,
    input  logic               bit_i,
    input  logic [PAT_LEN-1:0] pattern_i,
    output logic               match_o
);

    localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [FILL_W-1:0]  fill_inc;
    logic               match_q, match_d;

    // Fill saturates at a full window; a hit empties it so matched bits are never reused.
    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        match_d  = 1'b0;
        fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_valid_i) begin
            hist_d = {hist_q[PAT_LEN-2:0], bit_i};
            if ((fill_inc == FILL_FULL) && (hist_d == pattern_i)) begin
                match_d = 1'b1;
                fill_d  = '0;
            end else begin
                fill_d = fill_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match_o = match_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Fetches command bytes, serializes them MSB-first into the detector and reports the match count.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int unsigned PAT_LEN = PAT_LEN_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pattern_scan_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    scan_state_e        state_q, state_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [7:0]         sreg_q, sreg_d;
    logic [2:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cmd_rdy_q, byte_rdy_q, res_vld_q, busy_q;

    logic cmd_hs, byte_hs, res_hs;
    logic det_clear, det_bit_valid, det_bit, det_match;

    always_comb begin
        state_d       = state_q;
        pat_d         = pat_q;
        rem_d         = rem_q;
        sreg_d        = sreg_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        det_clear     = 1'b0;
        det_bit_valid = 1'b0;
        det_bit       = sreg_q[7];
        cmd_hs        = bus.cmd_valid_i && cmd_rdy_q;
        byte_hs       = bus.byte_valid_i && byte_rdy_q;
        res_hs        = bus.res_ready_i && res_vld_q;

        if (det_match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    pat_d     = bus.cmd_pattern_i;
                    rem_d     = bus.cmd_len_i;
                    cnt_d     = '0;
                    det_clear = 1'b1;
                    state_d   = (bus.cmd_len_i != '0) ? FETCH : REPORT;
                end
            end
            FETCH: begin
                if (byte_hs) begin
                    sreg_d  = bus.byte_i;
                    idx_d   = 3'd7;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                det_bit_valid = 1'b1;
                sreg_d        = {sreg_q[6:0], 1'b0};
                idx_d         = idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? DRAIN : FETCH;
                end
            end
            // Lets a match completed by the last bit reach the counter before REPORT.
            DRAIN: state_d = REPORT;
            REPORT: begin
                if (res_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered decodes of the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            rem_q      <= '0;
            sreg_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            cmd_rdy_q  <= 1'b1;
            byte_rdy_q <= 1'b0;
            res_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            rem_q      <= rem_d;
            sreg_q     <= sreg_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            cmd_rdy_q  <= (state_d == IDLE);
            byte_rdy_q <= (state_d == FETCH);
            res_vld_q  <= (state_d == REPORT);
            busy_q     <= (state_d != IDLE);
        end
    end

    pattern_det_nonover #(
        .PAT_LEN (PAT_LEN)
    ) u_det (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (det_clear),
        .bit_valid_i (det_bit_valid),
        .bit_i       (det_bit),
        .pattern_i   (pat_q),
        .match_o     (det_match)
    );

    assign bus.cmd_ready_o  = cmd_rdy_q;
    assign bus.byte_ready_o = byte_rdy_q;
    assign bus.res_valid_o  = res_vld_q;
    assign bus.res_count_o  = cnt_q;
    assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: a default instance and a 2-bit-counter instance run in lockstep.
module tb_pattern_scan_ctrl;
    import pattern_scan_pkg::*;

    localparam int unsigned PL  = 5;
    localparam int unsigned LW  = 8;
    localparam int unsigned CW  = 8;
    localparam int unsigned CWS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic [7:0] stim [16];

    pattern_scan_ctrl_if #(.PAT_LEN(PL), .LEN_W(LW), .CNT_W(CW))  m_if ();
    pattern_scan_ctrl_if #(.PAT_LEN(PL), .LEN_W(LW), .CNT_W(CWS)) s_if ();

    assign s_if.cmd_valid_i   = m_if.cmd_valid_i;
    assign s_if.cmd_len_i     = m_if.cmd_len_i;
    assign s_if.cmd_pattern_i = m_if.cmd_pattern_i;
    assign s_if.byte_valid_i  = m_if.byte_valid_i;
    assign s_if.byte_i        = m_if.byte_i;
    assign s_if.res_ready_i   = m_if.res_ready_i;

    pattern_scan_ctrl #(.PAT_LEN(PL), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (m_if.slave)
    );

    pattern_scan_ctrl #(.PAT_LEN(PL), .LEN_W(LW), .CNT_W(CWS)) dut_sat (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (s_if.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Reference non-overlapping detector over stim[0..len-1], MSB first.
    function automatic int model_count(input int len, input logic [PL-1:0] pat);
        logic [PL-1:0] h;
        logic [7:0]    b;
        int fill, n;
        h = '0; fill = 0; n = 0;
        for (int k = 0; k < len; k++) begin
            b = stim[k];
            for (int i = 7; i >= 0; i--) begin
                h = {h[PL-2:0], b[i]};
                if (fill < int'(PL)) fill++;
                if (fill == int'(PL) && h == pat) begin
                    n++;
                    fill = 0;
                end
            end
        end
        return n;
    endfunction

    // Issues a command, feeds stim[] and waits for res_valid_o; lat is the cycle index of res_valid_o.
    task automatic run_cmd(input int len, input logic [PL-1:0] pat, input int gap,
                           output int lat, output bit saw_brdy);
        int guard;
        lat = 0;
        saw_brdy = 1'b0;
        m_if.cmd_len_i     = LW'(len);
        m_if.cmd_pattern_i = pat;
        m_if.cmd_valid_i   = 1'b1;
        guard = 0;
        while (!m_if.cmd_ready_o && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready_o=%b required 1", m_if.cmd_ready_o);
            m_if.cmd_valid_i = 1'b0;
            return;
        end
        step();
        m_if.cmd_valid_i = 1'b0;
        fork
            begin
                for (int b = 0; b < len; b++) begin
                    int g;
                    g = 0;
                    m_if.byte_i       = stim[b];
                    m_if.byte_valid_i = 1'b1;
                    while (!m_if.byte_ready_o && g < 100) begin
                        step();
                        g++;
                    end
                    step();
                    if (gap > 0) begin
                        m_if.byte_valid_i = 1'b0;
                        repeat (gap) step();
                    end
                end
                m_if.byte_valid_i = 1'b0;
            end
            begin
                lat = 1;
                while (!m_if.res_valid_o && lat < 1000) begin
                    if (m_if.byte_ready_o) saw_brdy = 1'b1;
                    step();
                    lat++;
                end
                if (m_if.byte_ready_o) saw_brdy = 1'b1;
            end
        join
    endtask

    task automatic finish_res();
        m_if.res_ready_i = 1'b1;
        step();
        m_if.res_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if (m_if.cmd_ready_o !== 1'b1 || m_if.byte_ready_o !== 1'b0 || m_if.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_busy: cmd_ready=%b byte_ready=%b busy=%b required 1 0 0",
                     m_if.cmd_ready_o, m_if.byte_ready_o, m_if.busy_o);
        end
        checks++;
        if (m_if.res_valid_o !== 1'b0 || m_if.res_count_o !== 8'd0 || s_if.res_count_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_result: res_valid=%b count=%0d sat_count=%0d required 0 0 0",
                     m_if.res_valid_o, m_if.res_count_o, s_if.res_count_o);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_nonoverlap();
        int lat, e;
        bit saw;
        stim[0] = 8'h6D;
        exp_q.push_back(1);
        run_cmd(1, 5'b01101, 0, lat, saw);
        e = exp_q.pop_front();
        checks++;
        if (m_if.res_valid_o !== 1'b1 || m_if.res_count_o !== CW'(e)) begin
            errors++;
            $display("FAIL nonoverlap_count: valid=%b count=%0d required 1 %0d",
                     m_if.res_valid_o, m_if.res_count_o, e);
        end
        checks++;
        if (lat != 11) begin
            errors++;
            $display("FAIL nonoverlap_latency: %0d cycles required 11", lat);
        end
        checks++;
        if (m_if.busy_o !== 1'b1 || m_if.cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL report_busy: busy=%b cmd_ready=%b required 1 0", m_if.busy_o, m_if.cmd_ready_o);
        end
        finish_res();
        checks++;
        if (m_if.cmd_ready_o !== 1'b1 || m_if.busy_o !== 1'b0 || m_if.res_count_o !== CW'(e)) begin
            errors++;
            $display("FAIL after_report: cmd_ready=%b busy=%b count=%0d required 1 0 %0d",
                     m_if.cmd_ready_o, m_if.busy_o, m_if.res_count_o, e);
        end
    endtask

    task automatic test_cross_byte();
        int lat, e;
        bit saw;
        stim[0] = 8'h6D;
        stim[1] = 8'h6D;
        exp_q.push_back(2);
        run_cmd(2, 5'b01101, 0, lat, saw);
        e = exp_q.pop_front();
        checks++;
        if (m_if.res_count_o !== CW'(e) || s_if.res_count_o !== CWS'(sat3(e))) begin
            errors++;
            $display("FAIL cross_byte_count: count=%0d sat=%0d required %0d %0d",
                     m_if.res_count_o, s_if.res_count_o, e, sat3(e));
        end
        checks++;
        if (lat != 20) begin
            errors++;
            $display("FAIL cross_byte_latency: %0d cycles required 20", lat);
        end
        finish_res();
    endtask

    task automatic test_len_zero();
        int lat, e;
        bit saw;
        exp_q.push_back(0);
        run_cmd(0, 5'b10101, 0, lat, saw);
        e = exp_q.pop_front();
        checks++;
        if (m_if.res_valid_o !== 1'b1 || m_if.res_count_o !== CW'(e) || lat != 1) begin
            errors++;
            $display("FAIL len_zero: valid=%b count=%0d lat=%0d required 1 %0d 1",
                     m_if.res_valid_o, m_if.res_count_o, lat, e);
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL len_zero_byte_ready: byte_ready seen=%b required 0", saw);
        end
        finish_res();
    endtask

    task automatic test_saturation();
        int lat, e;
        bit saw;
        for (int i = 0; i < 4; i++) stim[i] = 8'h00;
        exp_q.push_back(6);
        run_cmd(4, 5'b00000, 12, lat, saw);
        e = exp_q.pop_front();
        checks++;
        if (m_if.res_count_o !== CW'(e)) begin
            errors++;
            $display("FAIL zero_run_count: count=%0d required %0d", m_if.res_count_o, e);
        end
        checks++;
        if (s_if.res_valid_o !== 1'b1 || s_if.res_count_o !== CWS'(sat3(e))) begin
            errors++;
            $display("FAIL saturated_count: valid=%b count=%0d required 1 %0d",
                     s_if.res_valid_o, s_if.res_count_o, sat3(e));
        end
        finish_res();
    endtask

    task automatic test_hold();
        int lat, e;
        bit saw;
        stim[0] = 8'h6D;
        exp_q.push_back(1);
        run_cmd(1, 5'b01101, 0, lat, saw);
        e = exp_q.pop_front();
        m_if.cmd_len_i   = '0;
        m_if.cmd_valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (m_if.res_valid_o !== 1'b1 || m_if.res_count_o !== CW'(e) || m_if.cmd_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b count=%0d cmd_ready=%b required 1 %0d 0",
                         c, m_if.res_valid_o, m_if.res_count_o, m_if.cmd_ready_o, e);
            end
        end
        exp_q.push_back(0);
        finish_res();
        checks++;
        if (m_if.cmd_ready_o !== 1'b1 || m_if.res_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: cmd_ready=%b valid=%b required 1 0",
                     m_if.cmd_ready_o, m_if.res_valid_o);
        end
        step();
        m_if.cmd_valid_i = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (m_if.res_valid_o !== 1'b1 || m_if.res_count_o !== CW'(e)) begin
            errors++;
            $display("FAIL hold_next_cmd: valid=%b count=%0d required 1 %0d",
                     m_if.res_valid_o, m_if.res_count_o, e);
        end
        finish_res();
    endtask

    task automatic test_reset_mid();
        int lat, e;
        bit saw;
        m_if.cmd_len_i     = LW'(2);
        m_if.cmd_pattern_i = 5'b01101;
        m_if.cmd_valid_i   = 1'b1;
        step();
        m_if.cmd_valid_i  = 1'b0;
        m_if.byte_i       = 8'h6D;
        m_if.byte_valid_i = 1'b1;
        step();
        repeat (8) step();
        step();
        repeat (3) step();
        checks++;
        if (m_if.busy_o !== 1'b1 || m_if.res_count_o !== 8'd1) begin
            errors++;
            $display("FAIL mid_cmd_progress: busy=%b count=%0d required 1 1", m_if.busy_o, m_if.res_count_o);
        end
        rst_n = 1'b0;
        #1;
        m_if.byte_valid_i = 1'b0;
        checks++;
        if (m_if.cmd_ready_o !== 1'b1 || m_if.byte_ready_o !== 1'b0 || m_if.res_valid_o !== 1'b0 ||
            m_if.res_count_o !== 8'd0 || m_if.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: cmd_ready=%b byte_ready=%b valid=%b count=%0d busy=%b required 1 0 0 0 0",
                     m_if.cmd_ready_o, m_if.byte_ready_o, m_if.res_valid_o, m_if.res_count_o, m_if.busy_o);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (m_if.res_valid_o !== 1'b0 || m_if.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b busy=%b required 0 0", m_if.res_valid_o, m_if.busy_o);
        end
        stim[0] = 8'h6D;
        exp_q.push_back(1);
        run_cmd(1, 5'b01101, 0, lat, saw);
        e = exp_q.pop_front();
        checks++;
        if (m_if.res_valid_o !== 1'b1 || m_if.res_count_o !== CW'(e) || lat != 11) begin
            errors++;
            $display("FAIL post_reset_cmd: valid=%b count=%0d lat=%0d required 1 %0d 11",
                     m_if.res_valid_o, m_if.res_count_o, lat, e);
        end
        finish_res();
    endtask

    task automatic test_back_to_back();
        int lat, e, len;
        bit saw;
        logic [PL-1:0] pat;
        for (int k = 0; k < 8; k++) begin
            len = int'($urandom_range(1, 4));
            pat = PL'($urandom);
            for (int i = 0; i < len; i++) stim[i] = 8'($urandom);
            if (k[0]) stim[0] = {pat, 3'($urandom)};
            exp_q.push_back(model_count(len, pat));
            run_cmd(len, pat, 0, lat, saw);
            e = exp_q.pop_front();
            checks++;
            if (m_if.res_count_o !== CW'(e) || s_if.res_count_o !== CWS'(sat3(e))) begin
                errors++;
                $display("FAIL b2b_count%0d: count=%0d sat=%0d required %0d %0d (pat=%b len=%0d)",
                         k, m_if.res_count_o, s_if.res_count_o, e, sat3(e), pat, len);
            end
            checks++;
            if (lat != 9 * len + 2) begin
                errors++;
                $display("FAIL b2b_latency%0d: %0d cycles required %0d", k, lat, 9 * len + 2);
            end
            finish_res();
        end
    endtask

    initial begin
        m_if.cmd_valid_i   = 1'b0;
        m_if.cmd_len_i     = '0;
        m_if.cmd_pattern_i = '0;
        m_if.byte_valid_i  = 1'b0;
        m_if.byte_i        = '0;
        m_if.res_ready_i   = 1'b0;
        test_reset();
        test_nonoverlap();
        test_cross_byte();
        test_len_zero();
        test_saturation();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
